// File: rtl/wave_controller.sv
// Game-flow controller for the astroid game: lives, score, level and the
// timed spawn request handshake toward the astroid datapath.
module wave_controller #(
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SPAWN_BASE = 1000,
  parameter int unsigned SPAWN_STEP = 100,
  parameter int unsigned SPAWN_MIN  = 300,
  parameter int unsigned LEVEL_PTS  = 4,
  parameter int unsigned RESPAWN_MS = 500,
  parameter int unsigned OVER_MS    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       fireButton,
  input  logic       hit_ship,
  input  logic       hit_astroid,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [1:0] spawn_slot,
  output logic [2:0] spawn_speed,
  output logic [1:0] game_state,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic [4:0] player_score
);

  localparam int unsigned TW = 11;
  localparam logic [TW-1:0] BASE_W    = TW'(SPAWN_BASE);
  localparam logic [TW-1:0] STEP_W    = TW'(SPAWN_STEP);
  localparam logic [TW-1:0] MIN_W     = TW'(SPAWN_MIN);
  localparam logic [TW-1:0] RESPAWN_W = TW'(RESPAWN_MS);
  localparam logic [TW-1:0] OVER_W    = TW'(OVER_MS);
  localparam logic [1:0]    LIVES_W   = 2'(LIVES);
  localparam logic [4:0]    SCORE_MAX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAY    = 2'b01,
    S_RESPAWN = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          ms_sync_q, ms_prev_q, fire_sync_q, fire_prev_q;
  logic [1:0]    lives_q, lives_d;
  logic [4:0]    score_q, score_d;
  logic [2:0]    level_q, level_d;
  logic [2:0]    speed_q, speed_d;
  logic [1:0]    slot_q, slot_d;
  logic          valid_q, valid_d;
  logic [TW-1:0] spawn_tmr_q, spawn_tmr_d;
  logic [TW-1:0] ms_tmr_q, ms_tmr_d;

  logic          tick, fire_rise, hold;
  logic [TW-1:0] step_amt, interval;
  logic [4:0]    quot;
  logic [3:0]    lvl_inc;

  // State and datapath registers; edge detectors clear with reset so no
  // spurious tick/fire_rise appears right after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ms_sync_q   <= 1'b0;
      ms_prev_q   <= 1'b0;
      fire_sync_q <= 1'b0;
      fire_prev_q <= 1'b0;
      lives_q     <= LIVES_W;
      score_q     <= 5'd0;
      level_q     <= 3'd0;
      speed_q     <= 3'd1;
      slot_q      <= 2'd0;
      valid_q     <= 1'b0;
      spawn_tmr_q <= '0;
      ms_tmr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ms_sync_q   <= clk_1ms;
      ms_prev_q   <= ms_sync_q;
      fire_sync_q <= fireButton;
      fire_prev_q <= fire_sync_q;
      lives_q     <= lives_d;
      score_q     <= score_d;
      level_q     <= level_d;
      speed_q     <= speed_d;
      slot_q      <= slot_d;
      valid_q     <= valid_d;
      spawn_tmr_q <= spawn_tmr_d;
      ms_tmr_q    <= ms_tmr_d;
    end
  end

  // Next-state, scoring and spawn logic.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    slot_d      = slot_q;
    valid_d     = valid_q;
    spawn_tmr_d = spawn_tmr_q;
    ms_tmr_d    = ms_tmr_q;
    tick        = ms_sync_q & ~ms_prev_q;
    fire_rise   = fire_sync_q & ~fire_prev_q;
    hold        = valid_q & ~spawn_ready;

    quot    = 5'(32'(score_q) / LEVEL_PTS);
    level_d = (quot > 5'd7) ? 3'd7 : quot[2:0];

    // Interval = max(BASE - level*STEP, MIN) without underflow.
    step_amt = {8'd0, level_q} * STEP_W;
    interval = (step_amt > (BASE_W - MIN_W)) ? MIN_W : (BASE_W - step_amt);

    case (state_q)
      S_IDLE: begin
        if (fire_rise) begin
          state_d     = S_PLAY;
          lives_d     = LIVES_W;
          score_d     = 5'd0;
          level_d     = 3'd0;
          spawn_tmr_d = '0;
          slot_d      = 2'd0;
          ms_tmr_d    = '0;
        end
      end
      S_PLAY: begin
        if (hit_astroid && (score_q != SCORE_MAX)) begin
          score_d = score_q + 5'd1;
        end
        if (valid_q) begin
          if (spawn_ready) begin
            valid_d = 1'b0;
            slot_d  = slot_q + 2'd1;
          end
        end else if (tick) begin
          if ((spawn_tmr_q + TW'(1)) >= interval) begin
            spawn_tmr_d = '0;
            valid_d     = 1'b1;
          end else begin
            spawn_tmr_d = spawn_tmr_q + TW'(1);
          end
        end
        if (hit_ship) begin
          lives_d  = lives_q - 2'd1;
          valid_d  = 1'b0;
          ms_tmr_d = '0;
          state_d  = (lives_q == 2'd1) ? S_OVER : S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        if (tick) begin
          if (ms_tmr_q == (RESPAWN_W - TW'(1))) begin
            ms_tmr_d = '0;
            state_d  = S_PLAY;
          end else begin
            ms_tmr_d = ms_tmr_q + TW'(1);
          end
        end
      end
      default: begin
        // Game over: hold for OVER_MS ticks before a restart is accepted.
        if (fire_rise && (ms_tmr_q >= OVER_W)) begin
          ms_tmr_d = '0;
          state_d  = S_IDLE;
        end else if (tick && (ms_tmr_q < OVER_W)) begin
          ms_tmr_d = ms_tmr_q + TW'(1);
        end
      end
    endcase

    lvl_inc = {1'b0, level_d} + 4'd1;
    speed_d = hold ? speed_q : ((lvl_inc > 4'd7) ? 3'd7 : lvl_inc[2:0]);
  end

  assign game_state   = state_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign player_score = score_q;
  assign spawn_valid  = valid_q;
  assign spawn_slot   = slot_q;
  assign spawn_speed  = speed_q;

endmodule

// File: tb/tb_wave_controller.sv
// Directed bench for wave_controller: spawn transfers are checked by a
// scoreboard monitor, state/score/lives by direct comparisons.
module tb_wave_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1ms, fireButton, hit_ship, hit_astroid, spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_slot, game_state, lives;
  logic [2:0] spawn_speed, level;
  logic [4:0] player_score;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  logic [4:0] exp_q[$];

  wave_controller dut (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .fireButton(fireButton),
    .hit_ship(hit_ship), .hit_astroid(hit_astroid),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_slot(spawn_slot), .spawn_speed(spawn_speed),
    .game_state(game_state), .lives(lives), .level(level),
    .player_score(player_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every transfer pops one expected {slot, speed}.
  always @(negedge clk) begin
    if (reset && spawn_valid && spawn_ready) begin
      total++;
      xfers++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got slot=%0d speed=%0d want none",
                 spawn_slot, spawn_speed);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({spawn_slot, spawn_speed} != e) begin
          bad++;
          $display("FAIL xfer: got slot=%0d speed=%0d want slot=%0d speed=%0d",
                   spawn_slot, spawn_speed, e[4:3], e[2:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      clk_1ms = 1'b1; @(negedge clk);
      clk_1ms = 1'b0; @(negedge clk);
    end
  endtask

  task automatic press_fire();
    fireButton = 1'b1; cyc(2);
    fireButton = 1'b0; cyc(2);
  endtask

  task automatic pulse(input bit ship, input bit ast);
    hit_ship = ship; hit_astroid = ast; @(negedge clk);
    hit_ship = 1'b0; hit_astroid = 1'b0; @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, int'(game_state), 0);
    check({tag, "_lives"}, int'(lives), 3);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_score"}, int'(player_score), 0);
    check({tag, "_valid"}, int'(spawn_valid), 0);
    check({tag, "_slot"}, int'(spawn_slot), 0);
    check({tag, "_speed"}, int'(spawn_speed), 1);
  endtask

  initial begin
    reset = 1'b0; clk_1ms = 1'b0; fireButton = 1'b0;
    hit_ship = 1'b0; hit_astroid = 1'b0; spawn_ready = 1'b0;
    cyc(3);
    check_reset_vals("rst");
    reset = 1'b1;
    cyc(3);
    check("idle_after_release", int'(game_state), 0);

    // Start game, first spawn after 1000 ticks.
    press_fire();
    check("start_state", int'(game_state), 1);
    check("start_lives", int'(lives), 3);
    check("start_score", int'(player_score), 0);
    spawn_ready = 1'b1;
    ticks(999); cyc(3);
    check("no_spawn_999", xfers, 0);
    exp_q.push_back({2'd0, 3'd1});
    ticks(1); cyc(3);
    check("spawn_1000", xfers, 1);
    check("slot_after_1", int'(spawn_slot), 1);

    // Back-pressure: request must hold steady and timer must freeze.
    spawn_ready = 1'b0;
    ticks(1000); cyc(3);
    check("stall_valid", int'(spawn_valid), 1);
    check("stall_slot", int'(spawn_slot), 1);
    check("stall_speed", int'(spawn_speed), 1);
    ticks(50); cyc(3);
    check("stall50_valid", int'(spawn_valid), 1);
    check("stall50_slot", int'(spawn_slot), 1);
    check("stall50_speed", int'(spawn_speed), 1);
    exp_q.push_back({2'd1, 3'd1});
    spawn_ready = 1'b1; cyc(2);
    check("stall_xfer", xfers, 2);
    check("stall_valid_drop", int'(spawn_valid), 0);
    check("slot_after_2", int'(spawn_slot), 2);
    ticks(999); cyc(3);
    check("frozen_timer", xfers, 2);
    exp_q.push_back({2'd2, 3'd1});
    ticks(1); cyc(3);
    check("spawn_3", xfers, 3);

    // Scoring raises the level and shortens the interval to 800.
    repeat (8) pulse(1'b0, 1'b1);
    cyc(2);
    check("score8", int'(player_score), 8);
    check("level2", int'(level), 2);
    check("speed3", int'(spawn_speed), 3);
    ticks(799); cyc(3);
    check("no_spawn_799", xfers, 3);
    exp_q.push_back({2'd3, 3'd3});
    ticks(1); cyc(3);
    check("spawn_800", xfers, 4);
    check("slot_wrap", int'(spawn_slot), 0);

    // First ship hit; hits and fire ignored during the respawn pause.
    pulse(1'b1, 1'b0); cyc(1);
    check("hit1_lives", int'(lives), 2);
    check("hit1_state", int'(game_state), 2);
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); press_fire();
    check("resp_ign_lives", int'(lives), 2);
    check("resp_ign_score", int'(player_score), 8);
    check("resp_ign_state", int'(game_state), 2);
    ticks(499); cyc(2);
    check("resp_499", int'(game_state), 2);
    ticks(1); cyc(2);
    check("resp_500", int'(game_state), 1);

    // Simultaneous hits while a spawn request is pending.
    spawn_ready = 1'b0;
    ticks(800); cyc(3);
    check("pend_valid", int'(spawn_valid), 1);
    check("pend_slot", int'(spawn_slot), 0);
    hit_ship = 1'b1; hit_astroid = 1'b1; @(negedge clk);
    hit_ship = 1'b0; hit_astroid = 1'b0;
    check("both_valid", int'(spawn_valid), 0);
    check("both_state", int'(game_state), 2);
    check("both_lives", int'(lives), 1);
    check("both_score", int'(player_score), 9);
    ticks(500); cyc(2);
    check("resp2_done", int'(game_state), 1);

    // Saturation at 31, level 7, interval 300; aborted request kept slot 0.
    repeat (31) pulse(1'b0, 1'b1);
    cyc(2);
    check("score_sat", int'(player_score), 31);
    check("level7", int'(level), 7);
    check("speed7", int'(spawn_speed), 7);
    spawn_ready = 1'b1;
    ticks(299); cyc(3);
    check("no_spawn_299", xfers, 4);
    exp_q.push_back({2'd0, 3'd7});
    ticks(1); cyc(3);
    check("spawn_300", xfers, 5);

    // Final hit, game-over hold.
    pulse(1'b1, 1'b0); cyc(1);
    check("over_state", int'(game_state), 3);
    check("over_lives", int'(lives), 0);
    pulse(1'b1, 1'b0);
    check("over_hit_ign", int'(lives), 0);
    ticks(999); cyc(2);
    press_fire();
    check("over_fire_999", int'(game_state), 3);
    check("over_score_hold", int'(player_score), 31);
    check("over_level_hold", int'(level), 7);
    ticks(1); cyc(2);
    press_fire();
    check("over_fire_1000", int'(game_state), 0);

    // Restart, then asynchronous reset mid-handshake.
    press_fire();
    check("restart_state", int'(game_state), 1);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(player_score), 0);
    check("restart_level", int'(level), 0);
    spawn_ready = 1'b0;
    ticks(1000); cyc(3);
    check("pre_rst_valid", int'(spawn_valid), 1);
    @(negedge clk); #2 reset = 1'b0; #1;
    check_reset_vals("async_rst");
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_controller.md
WAVE_CONTROLLER -- requirements
Module: wave_controller

Interface
REQ-001 Parameters SHALL be:
- LIVES, 3, starting lives (1..3)
- SPAWN_BASE, 1000, level-0 spawn interval in ms ticks
- SPAWN_STEP, 100, interval reduction per level
- SPAWN_MIN, 300, interval floor
- LEVEL_PTS, 4, score points per level
- RESPAWN_MS, 500, respawn pause in ms ticks
- OVER_MS, 1000, minimum game-over hold in ms ticks
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock; the only clock
- reset, in, 1, asynchronous, active-low reset
- clk_1ms, in, 1, divided 1 ms clock, sampled in the clk domain; each rising edge is one ms tick
- fireButton, in, 1, start/restart request; its rising edge is the event
- hit_ship, in, 1, one-cycle pulse: an astroid has collided with the ship
- hit_astroid, in, 1, one-cycle pulse: a rocket has destroyed an astroid
- spawn_valid, out, 1, spawn request to the astroid datapath
- spawn_ready, in, 1, astroid datapath accepts the spawn
- spawn_slot, out, 2, astroid slot to spawn into
- spawn_speed, out, 3, speed of the spawned astroid
- game_state, out, 2, 00 IDLE, 01 PLAY, 10 RESPAWN, 11 OVER
- lives, out, 2, remaining lives
- level, out, 3, current difficulty level
- player_score, out, 5, current score

Function
REQ-003 The block SHALL register clk_1ms and fireButton and derive single-cycle rising-edge pulses tick and fire_rise; tick and fire_rise SHALL NOT fire in the first cycle after reset release.
REQ-004 The FSM SHALL have exactly four states: IDLE, PLAY, RESPAWN and OVER. game_state SHALL be registered.
REQ-005 In IDLE, fire_rise SHALL cause a transition to PLAY on the next cycle. The same edge SHALL load lives=LIVES and clear player_score, level, the spawn timer and spawn_slot.
REQ-006 In PLAY, hit_ship SHALL decrement lives. If lives was 1, the FSM SHALL go to OVER with lives=0; otherwise it SHALL go to RESPAWN.
REQ-007 In RESPAWN, the block SHALL count RESPAWN_MS ticks and then return to PLAY. hit_ship, hit_astroid and fire_rise SHALL be ignored during RESPAWN.
REQ-008 In OVER, the block SHALL count ticks. fire_rise SHALL be ignored until OVER_MS ticks have elapsed; after that, fire_rise SHALL go to IDLE. player_score and level SHALL hold their values in OVER.
REQ-009 hit_ship SHALL be ignored in IDLE and OVER.
REQ-010 In PLAY only, hit_astroid SHALL increment player_score, saturating at 31.
REQ-011 level SHALL equal min(player_score / LEVEL_PTS, 7) and SHALL update in the cycle after the score changes.
REQ-012 spawn_speed SHALL equal min(level+1, 7).
REQ-013 spawn interval SHALL equal max(SPAWN_BASE - level*SPAWN_STEP, SPAWN_MIN), computed at 11-bit width without underflow.
REQ-014 The spawn timer SHALL increment on tick only while in PLAY with spawn_valid low. When the timer reaches the spawn interval, it SHALL clear and spawn_valid SHALL assert on the next cycle.
REQ-015 Spawn handshake:
- spawn_valid, spawn_slot and spawn_speed SHALL stay stable while spawn_valid=1 and spawn_ready=0.
- A transfer SHALL occur in a cycle where spawn_valid and spawn_ready are both 1.
- After a transfer, spawn_valid SHALL deassert on the next cycle and spawn_slot SHALL increment modulo 4.
REQ-016 Leaving PLAY SHALL deassert spawn_valid on the next cycle without a transfer. spawn_slot SHALL be unchanged and the spawn timer SHALL hold its value.
REQ-017 If hit_ship and hit_astroid occur in the same PLAY cycle, the score increment and the life decrement SHALL both take effect.
REQ-018 spawn_ready while spawn_valid=0 SHALL have no effect.

Reset
REQ-019 While reset=0, asynchronously: game_state=IDLE, lives=LIVES, level=0, player_score=0, spawn_valid=0, spawn_slot=0, spawn_speed=1; all timers and edge registers SHALL be 0.
REQ-020 Asserting reset in any state, including mid-handshake, SHALL drop spawn_valid immediately; reset release SHALL resume in IDLE.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, then fire_rise -> game_state=01, lives=3, player_score=0. After 1000 ticks with spawn_ready=1 -> one transfer with spawn_slot=0, spawn_speed=1.
- spawn_ready held 0 for 50 ticks -> spawn_valid, spawn_slot and spawn_speed stable and timer frozen. Then ready=1 -> one transfer and spawn_slot=1.
- 8 hit_astroid pulses -> player_score=8, level=2, spawn_speed=3, interval 800. 31 further pulses -> player_score saturates at 31, level=7, interval 300.
- 3 hit_ship pulses separated by respawns -> lives 2, 1, 0. RESPAWN lasts 500 ticks and hits during it are ignored. Third hit -> game_state=11. fire_rise at tick 999 of OVER ignored; at tick 1000 -> IDLE.
- hit_ship and hit_astroid in the same PLAY cycle with lives=2 -> player_score+1, lives=1, state RESPAWN, spawn_valid low the next cycle.
- reset pulled low during spawn_valid=1 -> spawn_valid=0 with no clock edge; all outputs at REQ-019 values.
